lagarto_plic_target_controller: RTL

Hart-side endpoint of the PLIC target interface. It consumes interrupt_notification/interrupt_id from lagarto_plic and raises the external interrupt to the Lagarto core. It turns the core's claim and complete requests into the single-cycle interrupt_claim/interrupt_complete pulses the PLIC gateways expect. It tracks one in-service interrupt (no nesting), checks the completion ID, and runs a service watchdog.

---
 rtl/lagarto_plic_target_controller_if.sv | 40 ++++
 rtl/lagarto_plic_target_controller.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/lagarto_plic_target_controller_if.sv
// PLIC target-side signal bundle: PLIC notification/ID in, claim/complete
// pulses out, plus the core's claim/complete register handshake.
interface lagarto_plic_target_controller_if #(
   parameter int unsigned MXLEN = 64
);
   // PLIC side
   logic             interrupt_notification_i;
   logic [MXLEN-1:0] interrupt_id_i;
   logic             interrupt_claim_o;
   logic             interrupt_complete_o;
   // Core side
   logic             target_enable_i;
   logic             external_interrupt_o;
   logic             claim_req_i;
   logic             claim_ack_o;
   logic [MXLEN-1:0] claimed_id_o;
   logic             complete_req_i;
   logic [MXLEN-1:0] complete_id_i;
   logic             complete_ack_o;
   logic             complete_error_o;
   logic             service_timeout_o;

   // Controller view
   modport slave (
      input  interrupt_notification_i, interrupt_id_i, target_enable_i,
             claim_req_i, complete_req_i, complete_id_i,
      output interrupt_claim_o, interrupt_complete_o, external_interrupt_o,
             claim_ack_o, claimed_id_o, complete_ack_o, complete_error_o,
             service_timeout_o
   );

   // Environment view (PLIC + core)
   modport master (
      output interrupt_notification_i, interrupt_id_i, target_enable_i,
             claim_req_i, complete_req_i, complete_id_i,
      input  interrupt_claim_o, interrupt_complete_o, external_interrupt_o,
             claim_ack_o, claimed_id_o, complete_ack_o, complete_error_o,
             service_timeout_o
   );
endinterface

// File: rtl/lagarto_plic_target_controller.sv
// Hart-side PLIC target endpoint: raises MEIP, converts core claim/complete
// register accesses into single-cycle PLIC pulses, tracks one in-service
// interrupt and runs a service watchdog.
module lagarto_plic_target_controller #(
   // Interrupt ID width; normally MXLEN from riscv_privileged_pkg, exposed
   // here so the block elaborates on its own.
   parameter int unsigned MXLEN          = 64,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   // Derived watchdog width; leave at default.
   parameter int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                              clk_i,
   input  logic                              rstn_i,
   lagarto_plic_target_controller_if.slave   tgt
);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_PENDING    = 3'd1,
      ST_CLAIMING   = 3'd2,
      ST_SERVICING  = 3'd3,
      ST_COMPLETING = 3'd4
   } state_t;

   localparam logic [CNT_WIDTH-1:0] WDOG_MAX = CNT_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [CNT_WIDTH-1:0] WDOG_ONE = CNT_WIDTH'(1);

   state_t             state_q;
   logic [MXLEN-1:0]   latched_id_q;
   logic [CNT_WIDTH-1:0] wdog_q;

   logic               claim_q;
   logic               complete_q;
   logic               meip_q;
   logic               claim_ack_q;
   logic [MXLEN-1:0]   claimed_id_q;
   logic               complete_ack_q;
   logic               complete_err_q;
   logic               timeout_q;

   logic               id_valid;
   logic               pend_req;
   logic               complete_match;
   logic [CNT_WIDTH-1:0] wdog_inc;

   // Decoded request conditions and saturating watchdog increment
   assign id_valid       = |tgt.interrupt_id_i;
   assign pend_req       = tgt.interrupt_notification_i & tgt.target_enable_i & id_valid;
   assign complete_match = (tgt.complete_id_i == latched_id_q);
   assign wdog_inc       = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + WDOG_ONE;

   // Controller FSM with registered outputs
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q        <= ST_IDLE;
         latched_id_q   <= '0;
         wdog_q         <= '0;
         claim_q        <= 1'b0;
         complete_q     <= 1'b0;
         meip_q         <= 1'b0;
         claim_ack_q    <= 1'b0;
         claimed_id_q   <= '0;
         complete_ack_q <= 1'b0;
         complete_err_q <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         // Pulses default low; any claim is acked with ID 0 and any complete
         // is acked with error unless a state below accepts it.
         claim_q        <= 1'b0;
         complete_q     <= 1'b0;
         meip_q         <= 1'b0;
         claim_ack_q    <= tgt.claim_req_i;
         claimed_id_q   <= '0;
         complete_ack_q <= tgt.complete_req_i;
         complete_err_q <= tgt.complete_req_i;

         case (state_q)
            ST_IDLE: begin
               if (pend_req) begin
                  state_q <= ST_PENDING;
                  meip_q  <= 1'b1;
               end
            end

            ST_PENDING: begin
               // A claim beats a simultaneous retraction as long as an ID is present
               if (tgt.claim_req_i) begin
                  if (id_valid) begin
                     state_q      <= ST_CLAIMING;
                     latched_id_q <= tgt.interrupt_id_i;
                     claim_q      <= 1'b1;
                     claimed_id_q <= tgt.interrupt_id_i;
                     wdog_q       <= '0;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else if (!tgt.interrupt_notification_i || !tgt.target_enable_i) begin
                  state_q <= ST_IDLE;
               end else begin
                  meip_q <= 1'b1;
               end
            end

            ST_CLAIMING: begin
               // First servicing cycle counts as one
               state_q   <= ST_SERVICING;
               wdog_q    <= WDOG_ONE;
               timeout_q <= (WDOG_ONE >= WDOG_MAX);
            end

            ST_SERVICING: begin
               if (tgt.complete_req_i && complete_match) begin
                  state_q        <= ST_COMPLETING;
                  complete_q     <= 1'b1;
                  complete_err_q <= 1'b0;
                  wdog_q         <= '0;
                  timeout_q      <= 1'b0;
               end else begin
                  wdog_q <= wdog_inc;
                  if (wdog_inc == WDOG_MAX) begin
                     timeout_q <= 1'b1;
                  end
               end
            end

            ST_COMPLETING: begin
               // Notification ignored here so the gateway has a cycle to drop it
               state_q <= ST_IDLE;
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign tgt.interrupt_claim_o    = claim_q;
   assign tgt.interrupt_complete_o = complete_q;
   assign tgt.external_interrupt_o = meip_q;
   assign tgt.claim_ack_o          = claim_ack_q;
   assign tgt.claimed_id_o         = claimed_id_q;
   assign tgt.complete_ack_o       = complete_ack_q;
   assign tgt.complete_error_o     = complete_err_q;
   assign tgt.service_timeout_o    = timeout_q;

   // Claim and complete pulses are mutually exclusive
   a_pulse_excl: assert property (@(posedge clk_i) disable iff (!rstn_i)
      !(claim_q && complete_q));

   // Each PLIC pulse lasts a single cycle
   a_claim_single: assert property (@(posedge clk_i) disable iff (!rstn_i)
      claim_q |=> !claim_q);
   a_complete_single: assert property (@(posedge clk_i) disable iff (!rstn_i)
      complete_q |=> !complete_q);

endmodule
